// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and received-byte signals for the UART receiver.
//
// Signals:
//   rx          serial line into the receiver (idle high, asynchronous)
//   data        last received byte, held until the next byte completes
//   data_valid  one-cycle pulse when data holds a new good byte
//   frame_err   one-cycle pulse when the stop bit sampled low
//   parity_err  one-cycle pulse on even-parity mismatch (8E1 build only)
//   busy        receiver is inside a frame
//
// Modports:
//   master  the receiver: samples rx, drives the byte and status outputs
//   slave   the line driver / byte consumer
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output data_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  data_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB first, 115200 baud from 25 MHz.
// Default frame is 8N1; defining UART_RX_PARITY_EN switches to 8E1 and enables
// the parity_err output.
//
// Ports:
//   clk_25mhz  system clock
//   reset      asynchronous, active-high reset
//   bus        uart_rx_if.master: rx in; data, data_valid, frame_err,
//              parity_err, busy out
//
// Parameter:
//   DIVIDER    phase increment per clock; the accumulator carry is the 16x tick
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | line idle, waiting for rx_s low
// S_START   | counting to mid start bit to reject glitches
// S_DATA    | sampling 8 data bits at mid-bit, LSB first
// S_PARITY  | sampling even-parity bit (UART_RX_PARITY_EN only)
// S_STOP    | sampling stop bit, publishing the byte and status pulse
// S_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx #(
    parameter logic [15:0] DIVIDER = 16'd4832
) (
    input  logic     clk_25mhz,
    input  logic     reset,
    uart_rx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic       rx_meta, rx_s;
    logic [15:0] acc;
    logic       tick;
    logic [3:0] tcnt, tcnt_nxt;
    logic [2:0] bcnt, bcnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] data_q, data_nxt;
    logic       valid_q, valid_nxt;
    logic       ferr_q, ferr_nxt;
    logic       perr_nxt;
    logic       par_bad;
`ifdef UART_RX_PARITY_EN
    logic       par_bit, par_bit_nxt;
    logic       perr_q;
`endif

    // Synchronizer flops reset high so a reset does not look like a start edge.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running fractional divider; the carry-out is the 16x tick.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            acc  <= 16'd0;
            tick <= 1'b0;
        end else begin
            {tick, acc} <= {1'b0, acc} + {1'b0, DIVIDER};
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = (^shreg) ^ par_bit;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    tcnt_nxt  = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tcnt == 4'd7) begin
                        if (rx_s) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_DATA;
                            tcnt_nxt  = 4'd0;
                            bcnt_nxt  = 3'd0;
                        end
                    end else begin
                        tcnt_nxt = tcnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    // 16 ticks after mid start lands on mid of each data bit.
                    tcnt_nxt = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        shreg_nxt = {rx_s, shreg[7:1]};
                        bcnt_nxt  = bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = S_PARITY;
`else
                            state_nxt = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tcnt_nxt = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        par_bit_nxt = rx_s;
                        state_nxt   = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    tcnt_nxt = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        data_nxt = shreg;
                        // Leaving at mid stop bit absorbs baud mismatch and
                        // allows back-to-back frames.
                        if (rx_s) begin
                            valid_nxt = !par_bad;
                            perr_nxt  = par_bad;
                            state_nxt = S_IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = S_WAIT_HIGH;
                        end
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            tcnt    <= 4'd0;
            bcnt    <= 3'd0;
            shreg   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tcnt    <= tcnt_nxt;
            bcnt    <= bcnt_nxt;
            shreg   <= shreg_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            par_bit <= par_bit_nxt;
            perr_q  <= perr_nxt;
        end
    end
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = perr_nxt;
`endif

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int CPB = 256;

    logic clk_25mhz = 1'b0;
    logic reset     = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.DIVIDER(16'd4096)) dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .bus       (bus)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // kind: 0 = data_valid, 1 = frame_err, 2 = parity_err
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt;
    int   pulse_kind;
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [7:0] d);
        exp_t x;
        x.kind = kind;
        x.data = d;
        q.push_back(x);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a status pulse.
    always @(negedge clk_25mhz) begin
        if (reset) begin
            prev_pulse = 1'b0;
        end else begin
            pulse_cnt = int'(bus.data_valid) + int'(bus.frame_err) + int'(bus.parity_err);
            if (pulse_cnt != 0) begin
                check("pulse_exclusive", pulse_cnt, 1);
                check("pulse_width", {31'd0, prev_pulse}, 0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: dv=%0b fe=%0b pe=%0b data=%0h, expected none",
                             bus.data_valid, bus.frame_err, bus.parity_err, bus.data);
                end else begin
                    e = q.pop_front();
                    pulse_kind = bus.data_valid ? 0 : (bus.frame_err ? 1 : 2);
                    check("pulse_kind", pulse_kind, {30'd0, e.kind});
                    check("pulse_data", {24'd0, bus.data}, {24'd0, e.data});
                end
            end
            prev_pulse = (pulse_cnt != 0);
        end
    end

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk_25mhz);
    endtask

    task automatic send_bit(input logic b, input bit chk_busy);
        bus.rx = b;
        repeat (CPB / 2) @(negedge clk_25mhz);
        if (chk_busy) check("busy_in_frame", {31'd0, bus.busy}, 1);
        repeat (CPB - CPB / 2) @(negedge clk_25mhz);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input bit chk_busy);
        send_bit(1'b0, chk_busy);
        for (int i = 0; i < 8; i++) send_bit(d[i], chk_busy);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b, 1'b0);
`else
        if (par_b === 1'bx) bus.rx = 1'b1;
`endif
        send_bit(stop_b, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, bus.data}, 0);
        check({tag, "_data_valid"}, {31'd0, bus.data_valid}, 0);
        check({tag, "_frame_err"}, {31'd0, bus.frame_err}, 0);
        check({tag, "_parity_err"}, {31'd0, bus.parity_err}, 0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        logic [7:0] b;
        int waited;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk_25mhz);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(20);

        // 1: single byte, busy throughout
        push_exp(2'd0, 8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        idle(2 * CPB);

        // 2: back-to-back frames
        push_exp(2'd0, 8'hA5);
        push_exp(2'd0, 8'h3C);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(2 * CPB);

        // 3: short glitch rejected at mid start
        bus.rx = 1'b0;
        repeat (96) @(negedge clk_25mhz);
        idle(300);
        check("glitch_busy", {31'd0, bus.busy}, 0);

        // 4: framing error, held-low line, then recovery
        push_exp(2'd1, 8'h7E);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
        repeat (2000) @(negedge clk_25mhz);
        check("wait_high_busy", {31'd0, bus.busy}, 1);
        idle(16);
        check("after_break_busy", {31'd0, bus.busy}, 0);
        idle(CPB);
        push_exp(2'd0, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(2 * CPB);

        // 5: reset in bit 4 of 0xC3, line keeps running under reset
        b = 8'hC3;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        bus.rx = b[4];
        repeat (CPB / 2) @(negedge clk_25mhz);
        reset = 1'b1;
        repeat (2) @(negedge clk_25mhz);
        check_reset_outputs("midframe_reset");
        repeat (CPB - CPB / 2 - 2) @(negedge clk_25mhz);
        for (int i = 5; i < 8; i++) send_bit(b[i], 1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit(^b, 1'b0);
`endif
        send_bit(1'b1, 1'b0);
        idle(CPB);
        reset = 1'b0;
        idle(CPB);
        push_exp(2'd0, 8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        idle(2 * CPB);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then parity bad
        push_exp(2'd0, 8'h03);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        idle(CPB);
        push_exp(2'd2, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        idle(2 * CPB);
`endif

        waited = 0;
        while (q.size() != 0 && waited < 4 * CPB) begin
            @(negedge clk_25mhz);
            waited++;
        end
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(200000 * 40);
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end
endmodule
